// File: rtl/mem_readback_if.sv
// Memory read bus plus streamed-output valid/ready port of the readback engine.
// master = readback engine, slave = memory + consumer side.
interface mem_readback_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output mem_addr, mem_rd, out_data, out_addr, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd, out_data, out_addr, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mem_readback.sv
// Streams mem[base..base+count-1] out on a valid/ready port; READBACK_CSUM_EN appends a checksum beat.
// Start->first out_valid RD_LAT+2 cycles, one beat per RD_LAT+2; the next fetch waits while out_ready is low.
module mem_readback #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    output logic          busy,
    output logic          done,
    mem_readback_if.master bus
);
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
`ifdef READBACK_CSUM_EN
        ST_CSUM,
`endif
        ST_FIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef READBACK_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef READBACK_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef READBACK_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // mem_rd/mem_addr and done are registered one state ahead so they are
    // high exactly for the ISSUE and FIN cycles respectively.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef READBACK_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    rem_d      = {count == '0, count};
                    busy_d     = 1'b1;
                    mem_addr_d = base_addr;
                    mem_rd_d   = 1'b1;
                    state_d    = ST_ISSUE;
`ifdef READBACK_CSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_ISSUE: begin
                lat_d   = LW'(RD_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LW'(1)) begin
                    out_data_d  = bus.mem_rdata;
                    out_addr_d  = ptr_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    rem_d       = rem_q - (AW+1)'(1);
                    ptr_d       = ptr_q + AW'(1);
`ifdef READBACK_CSUM_EN
                    csum_d      = csum_q + out_data_q;
`endif
                    if (rem_q == (AW+1)'(1)) begin
`ifdef READBACK_CSUM_EN
                        out_data_d  = csum_q + out_data_q;
                        out_addr_d  = '1;
                        out_valid_d = 1'b1;
                        state_d     = ST_CSUM;
`else
                        done_d  = 1'b1;
                        state_d = ST_FIN;
`endif
                    end else begin
                        mem_addr_d = ptr_q + AW'(1);
                        mem_rd_d   = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
`ifdef READBACK_CSUM_EN
            ST_CSUM: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mem_readback.sv
// Directed-vector bench for mem_readback with a latency-accurate memory model and beat monitor.
module tb_mem_readback;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] base_addr, count;
    logic       busy, done;
    logic [7:0] mem [256];
    logic [7:0] pipe [RD_LAT];
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    mem_readback_if #(.AW(8), .DW(8)) bif ();

    mem_readback #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .bus(bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data appears RD_LAT cycles after the mem_rd cycle; junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= bif.mem_rd ? mem[bif.mem_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bif.mem_rdata = pipe[RD_LAT-1];

    // Monitor: accepted beats, valid rises, read strobes, done pulses, stall stability.
    logic [7:0] q_a[$], q_d[$];
    int         q_c[$], rise_q[$];
    int         rd_cnt = 0, done_cnt = 0, stab_err = 0, inv_err = 0;
    logic       prev_stall = 1'b0, prev_vld = 1'b0;
    logic [7:0] prev_a, prev_d;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_vld   = 1'b0;
        end else begin
            if (prev_stall && (!bif.out_valid || bif.out_data !== prev_d || bif.out_addr !== prev_a))
                stab_err++;
            if (bif.mem_rd) rd_cnt++;
            if (bif.mem_rd && bif.out_valid) inv_err++;
            if (done) done_cnt++;
            if (bif.out_valid && !prev_vld) rise_q.push_back(cyc);
            if (bif.out_valid && bif.out_ready) begin
                q_a.push_back(bif.out_addr);
                q_d.push_back(bif.out_data);
                q_c.push_back(cyc);
            end
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_vld   = bif.out_valid;
            prev_a     = bif.out_addr;
            prev_d     = bif.out_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] cnt;
        bit         rnd_rdy;
        int         n;
        logic [7:0] first_d;
        logic [7:0] last_a;
        logic [7:0] last_d;
        logic [7:0] csum;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int id, input vec_t v, input bit mid_start);
        int rd0, dn0, st0, iv0, qb, rb, start_cyc, nb, nd, seq_err, thr_err;
        logic [7:0] ea;
        bit fin;
        rd0 = rd_cnt; dn0 = done_cnt; st0 = stab_err; iv0 = inv_err;
        qb = q_a.size(); rb = rise_q.size();
        seq_err = 0; thr_err = 0; fin = 1'b0;
        @(posedge clk); #1;
        base_addr = v.base; count = v.cnt; start = 1'b1; bif.out_ready = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'h00; count = 8'h00;
        @(negedge clk);
        check($sformatf("v%0d_busy_after_start", id), busy, 1);
        for (int k = 0; k < 4000 && !fin; k++) begin
            @(posedge clk); #1;
            bif.out_ready = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = mid_start && (k == 5);
            base_addr = start ? 8'h40 : 8'h00;
            count     = start ? 8'h09 : 8'h00;
            @(negedge clk);
            if (done) fin = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; bif.out_ready = 1'b0;
        check($sformatf("v%0d_done_seen", id), fin, 1);
        @(negedge clk);
        check($sformatf("v%0d_busy_after_done", id), busy, 0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_pulses", id), done_cnt - dn0, 1);
        nb = q_a.size() - qb;
`ifdef READBACK_CSUM_EN
        check($sformatf("v%0d_beats", id), nb, v.n + 1);
        nd = (nb > 0) ? nb - 1 : 0;
        check($sformatf("v%0d_csum_addr", id), (nb > 0) ? q_a[qb+nb-1] : 8'hxx, 8'hFF);
        check($sformatf("v%0d_csum_data", id), (nb > 0) ? q_d[qb+nb-1] : 8'hxx, v.csum);
`else
        check($sformatf("v%0d_beats", id), nb, v.n);
        nd = nb;
`endif
        for (int i = 0; i < nd; i++) begin
            ea = v.base + 8'(i);
            if (q_a[qb+i] !== ea || q_d[qb+i] !== mem[ea]) seq_err++;
            if (i > 0 && q_c[qb+i] - q_c[qb+i-1] != RD_LAT + 2) thr_err++;
        end
        check($sformatf("v%0d_beat_seq_errs", id), seq_err, 0);
        check($sformatf("v%0d_first_data", id), (nd > 0) ? q_d[qb] : 8'hxx, v.first_d);
        check($sformatf("v%0d_last_addr", id), (nd > 0) ? q_a[qb+nd-1] : 8'hxx, v.last_a);
        check($sformatf("v%0d_last_data", id), (nd > 0) ? q_d[qb+nd-1] : 8'hxx, v.last_d);
        check($sformatf("v%0d_mem_rd_count", id), rd_cnt - rd0, v.n);
        check($sformatf("v%0d_stall_unstable", id), stab_err - st0, 0);
        check($sformatf("v%0d_rd_while_valid", id), inv_err - iv0, 0);
        check($sformatf("v%0d_first_latency", id),
              (rise_q.size() > rb) ? rise_q[rb] - start_cyc : -1, RD_LAT + 2);
        if (!v.rnd_rdy) check($sformatf("v%0d_throughput_errs", id), thr_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn0, rd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        //          base   cnt    rnd  n    first  last_a last_d csum
        vecs[0] = '{8'h10, 8'h04, 0,   4,   8'hB5, 8'h13, 8'hB6, 8'hD6};
        vecs[1] = '{8'hFE, 8'h03, 0,   3,   8'h5B, 8'h00, 8'hA5, 8'h5A};
        vecs[2] = '{8'h10, 8'h04, 1,   4,   8'hB5, 8'h13, 8'hB6, 8'hD6};
        vecs[3] = '{8'h00, 8'h00, 0,   256, 8'hA5, 8'hFF, 8'h5A, 8'h80};
        vecs[4] = '{8'h80, 8'h01, 1,   1,   8'h25, 8'h80, 8'h25, 8'h25};
        vecs[5] = '{8'h00, 8'h03, 0,   3,   8'h01, 8'h02, 8'h03, 8'h06};

        reset = 1'b1; start = 1'b0; base_addr = 8'h00; count = 8'h00;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", bif.mem_rd, 0);
        check("rst_mem_addr", bif.mem_addr, 0);
        check("rst_out_data", bif.out_data, 0);
        check("rst_out_addr", bif.out_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i], 1'b0);

        // Reset while beat 2 is held: abort without a done pulse.
        @(posedge clk); #1;
        dn0 = done_cnt;
        bif.out_ready = 1'b0; base_addr = 8'h10; count = 8'h04; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.out_valid) break;
        end
        check("abort_beat1_addr", bif.out_valid ? bif.out_addr : 8'hxx, 8'h10);
        @(posedge clk); #1; bif.out_ready = 1'b1;
        @(posedge clk); #1; bif.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.out_valid) break;
        end
        check("abort_beat2_addr", bif.out_valid ? bif.out_addr : 8'hxx, 8'h11);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bif.out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - dn0, 0);
        run_vec(6, vecs[0], 1'b0);

        // start coinciding with reset is dropped.
        @(posedge clk); #1;
        rd0 = rd_cnt;
        reset = 1'b1; start = 1'b1; base_addr = 8'h20; count = 8'h02;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("rst_start_no_rd", rd_cnt - rd0, 0);

        // Small block with a start pulse mid-run that must be ignored.
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        run_vec(7, vecs[5], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
